// File: rtl/cnt.sv
// cnt: synchronous loadable up/down counter (rst > load > en), registered output.
// Define CNT_SATURATE_EN to make counting saturate at the ends instead of wrapping.
module cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] count_in,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q, count_d, step;
    logic             at_lim;
    always_comb begin
        step    = up ? count_q + 1'b1 : count_q - 1'b1;
`ifdef CNT_SATURATE_EN
        at_lim  = up ? &count_q : ~|count_q;
`else
        at_lim  = 1'b0;
`endif
        count_d = load ? count_in : (en && !at_lim) ? step : count_q;
    end
    always_ff @(posedge clk) count_q <= rst ? '0 : count_d;
    assign count = count_q;
endmodule

// File: tb/tb_cnt.sv
// tb_cnt: scoreboard bench for cnt; a reference model pushes the expected
// value as each cycle is driven and it is popped when the DUT updates.
module tb_cnt;
    localparam int W = 4;
    logic         clk = 1'b0;
    logic         rst = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0;
    logic [W-1:0] count_in = '0;
    logic [W-1:0] count;
    logic [W-1:0] m;
    logic [W-1:0] sb[$];
    int           total = 0, bad = 0;

    cnt #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .count_in(count_in), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic r, input logic l, input logic e,
                       input logic u, input logic [W-1:0] ci);
        @(negedge clk);
        rst = r; load = l; en = e; up = u; count_in = ci;
        if (r) m = '0;
        else if (l) m = ci;
        else if (e) begin
`ifdef CNT_SATURATE_EN
            if (u) m = (m == {W{1'b1}}) ? m : m + 1'b1;
            else   m = (m == '0) ? m : m - 1'b1;
`else
            m = u ? m + 1'b1 : m - 1'b1;
`endif
        end
        sb.push_back(m);
        @(posedge clk);
        #1;
        chk(tag, count, sb.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        m = '0;
        cyc("rst0", 1, 1, 1, 1, 4'hA);
        cyc("rst1", 1, 1, 1, 1, 4'hA);
        chk("rst_const", count, 4'h0);
        for (int i = 0; i < 17; i++) cyc("up", 0, 0, 1, 1, 4'h0);
`ifdef CNT_SATURATE_EN
        chk("up17_const", count, 4'hF);
`else
        chk("up17_const", count, 4'h1);
`endif
        cyc("load2", 0, 1, 0, 0, 4'h2);
        chk("load2_const", count, 4'h2);
        for (int i = 0; i < 4; i++) cyc("down", 0, 0, 1, 0, 4'h0);
`ifdef CNT_SATURATE_EN
        chk("down4_const", count, 4'h0);
`else
        chk("down4_const", count, 4'hE);
`endif
        cyc("load5", 0, 1, 0, 0, 4'h5);
        for (int i = 0; i < 3; i++) cyc("hold", 0, 0, 0, i[0], 4'h3);
        chk("hold_const", count, 4'h5);
        cyc("prio", 0, 1, 1, 1, 4'h9);
        chk("prio_const", count, 4'h9);
        cyc("load6", 0, 1, 0, 0, 4'h6);
        cyc("up7", 0, 0, 1, 1, 4'h0);
        chk("at7_const", count, 4'h7);
        cyc("midrst", 1, 0, 1, 1, 4'h0);
        chk("midrst_const", count, 4'h0);
        cyc("resume", 0, 0, 1, 1, 4'h0);
        chk("resume_const", count, 4'h1);
        for (int i = 0; i < 3; i++) cyc("loadhold", 0, 1, 1, 0, 4'(i + 10));
        chk("loadhold_const", count, 4'hC);
        for (int i = 0; i < 200; i++)
            cyc("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
                1'($urandom), 1'($urandom), 4'($urandom));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
